// File: rtl/decode_scoreboard.sv
// Decode-stage register scoreboard: per-register outstanding-write counters and
// latency timers produce a stall request. Define SCOREBOARD_FWD_EN to release sources once their timer expires.
module decode_scoreboard #(
   parameter  int NREGS  = 32,
   parameter  int LAT_W  = 3,
   parameter  int CNT_W  = 2,
   localparam int RIDX_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              Rst,
   input  logic              dbg,
   input  logic              mem_hold,
   input  logic              issue_valid,
   input  logic [RIDX_W-1:0] issue_rd,
   input  logic [LAT_W-1:0]  issue_lat,
   input  logic [RIDX_W-1:0] chk_rs1,
   input  logic [RIDX_W-1:0] chk_rs2,
   input  logic              chk_rs1_used,
   input  logic              chk_rs2_used,
   input  logic [RIDX_W-1:0] chk_rd,
   input  logic              chk_rd_used,
   input  logic              wb_valid,
   input  logic [RIDX_W-1:0] wb_rd,
   output logic              hz,
   output logic [NREGS-1:0]  pend_vec,
   output logic              err
);

   logic [CNT_W-1:0] cnt_q [NREGS];
   logic [CNT_W-1:0] cnt_d [NREGS];
   logic [LAT_W-1:0] tmr_q [NREGS];
   logic [LAT_W-1:0] tmr_d [NREGS];
   logic             err_q, err_d;

   logic frz, iss_acc, wb_hit, wb_acc, blk_rs1, blk_rs2;

   // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      err_d   = err_q;
      frz     = dbg | mem_hold;
      iss_acc = issue_valid & ~frz & (issue_rd != '0);
      wb_hit  = wb_valid & ~frz & (wb_rd != '0);
      wb_acc  = wb_hit & (cnt_q[wb_rd] != '0);

      if (!frz) begin
         for (int r = 1; r < NREGS; r++) begin
            if (tmr_q[r] != '0) tmr_d[r] = tmr_q[r] - LAT_W'(1);
         end
      end

      if (wb_hit && cnt_q[wb_rd] == '0) err_d = 1'b1;
      if (iss_acc) tmr_d[issue_rd] = issue_lat;

      // A matched issue/writeback pair cancels, even when the counter is saturated.
      if (!(iss_acc && wb_acc && issue_rd == wb_rd)) begin
         if (wb_acc) cnt_d[wb_rd] = cnt_q[wb_rd] - CNT_W'(1);
         if (iss_acc) begin
            if (cnt_q[issue_rd] == '1) err_d = 1'b1;
            else                       cnt_d[issue_rd] = cnt_q[issue_rd] + CNT_W'(1);
         end
      end

      cnt_d[0] = '0;
      tmr_d[0] = '0;
   end

   // NOTE: the counter/timer arrays are control state, not data storage, so every entry is reset.
   always_ff @(posedge clk) begin
      if (Rst) begin
         for (int r = 0; r < NREGS; r++) begin
            cnt_q[r] <= '0;
            tmr_q[r] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmr_q <= tmr_d;
         err_q <= err_d;
      end
   end

   always_comb begin
`ifdef SCOREBOARD_FWD_EN
      blk_rs1 = (cnt_q[chk_rs1] != '0) & (tmr_q[chk_rs1] != '0);
      blk_rs2 = (cnt_q[chk_rs2] != '0) & (tmr_q[chk_rs2] != '0);
`else
      blk_rs1 = (cnt_q[chk_rs1] != '0);
      blk_rs2 = (cnt_q[chk_rs2] != '0);
`endif
      hz = (chk_rs1_used & blk_rs1) | (chk_rs2_used & blk_rs2) |
           (chk_rd_used & ((tmr_q[chk_rd] != '0) | (cnt_q[chk_rd] == '1)));
   end

   always_comb begin
      pend_vec = '0;
      for (int r = 0; r < NREGS; r++) pend_vec[r] = (cnt_q[r] != '0);
   end

   assign err = err_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Self-checking bench for decode_scoreboard: directed vector table plus randomized
// traffic compared against an integer reference model.
module tb_decode_scoreboard;

   localparam int NREGS   = 32;
   localparam int CNT_MAX = 3;
`ifdef SCOREBOARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        Rst, dbg, mem_hold, issue_valid, wb_valid;
   logic        chk_rs1_used, chk_rs2_used, chk_rd_used;
   logic [4:0]  issue_rd, chk_rs1, chk_rs2, chk_rd, wb_rd;
   logic [2:0]  issue_lat;
   logic        hz, err;
   logic [31:0] pend_vec;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   decode_scoreboard dut (
      .clk(clk), .Rst(Rst), .dbg(dbg), .mem_hold(mem_hold),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_lat(issue_lat),
      .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rs1_used(chk_rs1_used),
      .chk_rs2_used(chk_rs2_used), .chk_rd(chk_rd), .chk_rd_used(chk_rd_used),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .hz(hz), .pend_vec(pend_vec), .err(err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst, dbg, mh, iv;
      logic [4:0]  ird;
      logic [2:0]  ilat;
      logic        wv;
      logic [4:0]  wrd, rs1;
      logic        rs1u;
      logic [4:0]  rd;
      logic        rdu, hz;
      logic [31:0] pend;
      logic        err;
   } vec_t;

   function automatic vec_t mk(bit rst, bit d, bit mh, bit iv, int ird, int ilat, bit wv, int wrd,
                               int rs1, bit rs1u, int rd, bit rdu, bit h, logic [31:0] p, bit e);
      vec_t v;
      v.rst = rst; v.dbg = d; v.mh = mh; v.iv = iv; v.ird = 5'(ird); v.ilat = 3'(ilat);
      v.wv = wv; v.wrd = 5'(wrd); v.rs1 = 5'(rs1); v.rs1u = rs1u; v.rd = 5'(rd); v.rdu = rdu;
      v.hz = h; v.pend = p; v.err = e;
      return v;
   endfunction

   // Reference model: plain integer counts and timers per register.
   int m_cnt [NREGS];
   int m_tmr [NREGS];
   bit m_err;

   function automatic bit model_hz();
      bit h1, h2, hd;
      h1 = chk_rs1 != 0 && m_cnt[chk_rs1] > 0 && (!FWD || m_tmr[chk_rs1] > 0);
      h2 = chk_rs2 != 0 && m_cnt[chk_rs2] > 0 && (!FWD || m_tmr[chk_rs2] > 0);
      hd = chk_rd != 0 && (m_tmr[chk_rd] > 0 || m_cnt[chk_rd] == CNT_MAX);
      return (chk_rs1_used && h1) || (chk_rs2_used && h2) || (chk_rd_used && hd);
   endfunction

   function automatic logic [31:0] model_pend();
      logic [31:0] p = '0;
      for (int r = 0; r < NREGS; r++) p[r] = m_cnt[r] > 0;
      return p;
   endfunction

   task automatic model_step();
      int delta [NREGS];
      if (Rst) begin
         for (int r = 0; r < NREGS; r++) begin m_cnt[r] = 0; m_tmr[r] = 0; end
         m_err = 0;
         return;
      end
      if (dbg || mem_hold) return;
      for (int r = 0; r < NREGS; r++) begin
         delta[r] = 0;
         if (m_tmr[r] > 0) m_tmr[r] = m_tmr[r] - 1;
      end
      if (issue_valid && issue_rd != 0) begin
         m_tmr[issue_rd] = int'(issue_lat);
         delta[issue_rd] = delta[issue_rd] + 1;
      end
      if (wb_valid && wb_rd != 0) begin
         if (m_cnt[wb_rd] == 0) m_err = 1;
         else delta[wb_rd] = delta[wb_rd] - 1;
      end
      for (int r = 1; r < NREGS; r++) begin
         if (m_cnt[r] + delta[r] > CNT_MAX) m_err = 1;
         else m_cnt[r] = m_cnt[r] + delta[r];
      end
   endtask

   vec_t tbl [27];

   initial begin
      Rst = 1; dbg = 0; mem_hold = 0; issue_valid = 0; issue_rd = 0; issue_lat = 0;
      wb_valid = 0; wb_rd = 0; chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
      chk_rs1_used = 0; chk_rs2_used = 0; chk_rd_used = 0;
      repeat (2) @(posedge clk);
      #1;

      //            rst d mh iv ird lat wv wrd rs1 u rd u   hz    pend      err
      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0,    32'h0,    0);
      tbl[1]  = mk(0, 0, 0, 1, 5, 2, 0, 0, 5, 1, 0, 0, 0,    32'h20,   0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 1,    32'h20,   0);
      tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 1,    32'h20,   0);
      tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, !FWD, 32'h20,   0);
      tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 5, 1, 0, 0, !FWD, 32'h0,    0);
      tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0,    32'h0,    0);
      tbl[7]  = mk(0, 0, 0, 1, 7, 3, 0, 0, 0, 0, 0, 0, 0,    32'h80,   0);
      tbl[8]  = mk(0, 0, 0, 1, 7, 5, 1, 7, 0, 0, 7, 1, 1,    32'h80,   0);
      tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 7, 1, 1,    32'h0,    0);
      tbl[10] = mk(0, 1, 0, 1, 3, 4, 0, 0, 0, 0, 7, 1, 1,    32'h0,    0);
      tbl[11] = mk(0, 0, 1, 0, 0, 0, 1, 9, 0, 0, 7, 1, 1,    32'h0,    0);
      tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0,    32'h0,    1);
      tbl[13] = mk(0, 0, 0, 1, 0, 7, 0, 0, 0, 1, 0, 1, 0,    32'h0,    1);
      tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 1,    32'h0,    1);
      tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    32'h0,    0);
      tbl[16] = mk(0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0,    32'h10,   0);
      tbl[17] = mk(0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 4, 1, 0,    32'h10,   0);
      tbl[18] = mk(0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0,    32'h10,   0);
      tbl[19] = mk(0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 4, 1, 1,    32'h10,   1);
      tbl[20] = mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 4, 1, 1,    32'h10,   1);
      tbl[21] = mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 4, 1, 0,    32'h10,   1);
      tbl[22] = mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0,    32'h0,    1);
      tbl[23] = mk(0, 0, 0, 1, 6, 7, 0, 0, 0, 0, 0, 0, 0,    32'h40,   1);
      tbl[24] = mk(0, 0, 0, 1, 6, 7, 0, 0, 0, 0, 0, 0, 0,    32'h40,   1);
      tbl[25] = mk(1, 0, 0, 0, 0, 0, 0, 0, 6, 1, 0, 0, 1,    32'h0,    0);
      tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 0, 0, 0,    32'h0,    0);

      for (int i = 0; i < 27; i++) begin
         Rst = tbl[i].rst; dbg = tbl[i].dbg; mem_hold = tbl[i].mh;
         issue_valid = tbl[i].iv; issue_rd = tbl[i].ird; issue_lat = tbl[i].ilat;
         wb_valid = tbl[i].wv; wb_rd = tbl[i].wrd;
         chk_rs1 = tbl[i].rs1; chk_rs1_used = tbl[i].rs1u;
         chk_rd = tbl[i].rd; chk_rd_used = tbl[i].rdu;
         chk_rs2 = 0; chk_rs2_used = 0;
         #1;
         check($sformatf("vec%0d hz", i), 64'(hz), 64'(tbl[i].hz));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d pend_vec", i), 64'(pend_vec), 64'(tbl[i].pend));
         check($sformatf("vec%0d err", i), 64'(err), 64'(tbl[i].err));
      end

      // Randomized traffic on a small register window to force collisions.
      Rst = 1; issue_valid = 0; wb_valid = 0; dbg = 0; mem_hold = 0;
      model_step();
      @(posedge clk);
      #1;
      for (int c = 0; c < 3000; c++) begin
         Rst          = ($urandom_range(0, 99) == 0);
         dbg          = ($urandom_range(0, 9) == 0);
         mem_hold     = ($urandom_range(0, 9) == 0);
         issue_valid  = $urandom_range(0, 1) == 1;
         issue_rd     = 5'($urandom_range(0, 7));
         issue_lat    = 3'($urandom_range(0, 7));
         wb_valid     = $urandom_range(0, 1) == 1;
         wb_rd        = 5'($urandom_range(1, 7));
         chk_rs1      = 5'($urandom_range(0, 7));
         chk_rs2      = 5'($urandom_range(0, 7));
         chk_rd       = 5'($urandom_range(0, 7));
         chk_rs1_used = $urandom_range(0, 1) == 1;
         chk_rs2_used = $urandom_range(0, 1) == 1;
         chk_rd_used  = $urandom_range(0, 1) == 1;
         #1;
         check($sformatf("rand%0d hz", c), 64'(hz), 64'(model_hz()));
         model_step();
         @(posedge clk);
         #1;
         check($sformatf("rand%0d pend_vec", c), 64'(pend_vec), 64'(model_pend()));
         check($sformatf("rand%0d err", c), 64'(err), 64'(m_err));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
